// File: rtl/speck_decrypt_core.sv
`default_nettype none
// ============================================================================
// Module      : speck_decrypt_core
// Description : Iterative SPECK64/128 decryption engine. Expands the 128-bit
//               key into a 27-entry round-key store (one step per clock),
//               then applies the inverse rounds from last to first, one per
//               clock. The stored schedule can be reused across blocks.
// Revision    : 1.0 - initial release
// ============================================================================
module speck_decrypt_core #(
    parameter int ROUNDS = 27,
    parameter int ALPHA  = 8,
    parameter int BETA   = 3
) (
    input  logic         clk,
    input  logic         reset_1,
    input  logic         start,
    input  logic         reuse_key,
    input  logic [63:0]  cipher_in,
    input  logic [127:0] key_in,
    output logic [63:0]  plain_out,
    output logic         busy,
    output logic         done,
    output logic         keys_valid
);

    localparam int                 c_cnt_w      = $clog2(ROUNDS);
    localparam logic [c_cnt_w-1:0] c_last_round = c_cnt_w'(ROUNDS - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_EXPAND  = 2'd1,
        S_DECRYPT = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_next_state;

    logic [31:0]          r_x;
    logic [31:0]          r_y;
    logic [31:0]          r_k;
    logic [31:0]          r_l0;
    logic [31:0]          r_l1;
    logic [31:0]          r_l2;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [31:0]          r_rk [0:ROUNDS-1];
    logic [63:0]          r_plain;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_keys_valid;

    logic                 w_reuse;
    logic                 w_last_step;
    logic                 w_cnt_zero;
    logic [31:0]          w_l_new;
    logic [31:0]          w_k_next;
    logic [31:0]          w_rk;
    logic [31:0]          w_y_new;
    logic [31:0]          w_x_new;

    function automatic logic [31:0] ror32(input logic [31:0] v, input int amt);
        return (v >> amt) | (v << (32 - amt));
    endfunction

    function automatic logic [31:0] rol32(input logic [31:0] v, input int amt);
        return (v << amt) | (v >> (32 - amt));
    endfunction

    // A reuse request is honoured only when a complete schedule is stored.
    assign w_reuse     = reuse_key & r_keys_valid;
    assign w_last_step = (r_cnt == c_last_round);
    assign w_cnt_zero  = (r_cnt == '0);

    // Key schedule step: l is a 3-word queue, r_l0 is the oldest word l[i].
    assign w_l_new  = (r_k + ror32(r_l0, ALPHA)) ^ 32'(r_cnt);
    assign w_k_next = rol32(r_k, BETA) ^ w_l_new;

    // Inverse round using the round key selected by the descending counter.
    assign w_rk    = r_rk[r_cnt];
    assign w_y_new = ror32(r_x ^ r_y, BETA);
    assign w_x_new = rol32((r_x ^ w_rk) - w_y_new, ALPHA);

    // State register.
    always_ff @(posedge clk or posedge reset_1) begin
        if (reset_1) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; start is only looked at while idle.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next_state = w_reuse ? S_DECRYPT : S_EXPAND;
                end
            end
            S_EXPAND: begin
                if (w_last_step) begin
                    w_next_state = S_DECRYPT;
                end
            end
            S_DECRYPT: begin
                if (w_cnt_zero) begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE: begin
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Datapath, round counter and registered status outputs.
    always_ff @(posedge clk or posedge reset_1) begin
        if (reset_1) begin
            r_x          <= '0;
            r_y          <= '0;
            r_k          <= '0;
            r_l0         <= '0;
            r_l1         <= '0;
            r_l2         <= '0;
            r_cnt        <= '0;
            r_plain      <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_keys_valid <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_x    <= cipher_in[63:32];
                        r_y    <= cipher_in[31:0];
                        r_busy <= 1'b1;
                        if (w_reuse) begin
                            r_cnt <= c_last_round;
                        end else begin
                            r_k          <= key_in[31:0];
                            r_l0         <= key_in[63:32];
                            r_l1         <= key_in[95:64];
                            r_l2         <= key_in[127:96];
                            r_keys_valid <= 1'b0;
                            r_cnt        <= '0;
                        end
                    end
                end
                S_EXPAND: begin
                    r_k  <= w_k_next;
                    r_l0 <= r_l1;
                    r_l1 <= r_l2;
                    r_l2 <= w_l_new;
                    if (w_last_step) begin
                        r_keys_valid <= 1'b1;
                        r_cnt        <= c_last_round;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DECRYPT: begin
                    r_x <= w_x_new;
                    r_y <= w_y_new;
                    if (!w_cnt_zero) begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_DONE: begin
                    r_plain <= {r_x, r_y};
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_busy <= 1'b0;
                end
            endcase
        end
    end

    // Round-key store; contents are qualified by keys_valid, so no reset.
    always_ff @(posedge clk) begin
        if (r_state == S_EXPAND) begin
            r_rk[r_cnt] <= r_k;
        end
    end

    assign plain_out  = r_plain;
    assign busy       = r_busy;
    assign done       = r_done;
    assign keys_valid = r_keys_valid;

endmodule
`default_nettype wire

// File: tb/tb_speck_decrypt_core.sv
`default_nettype none
// ============================================================================
// Module      : tb_speck_decrypt_core
// Description : Self-checking bench for speck_decrypt_core against a
//               behavioural SPECK64/128 model (key schedule, encrypt, decrypt).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_speck_decrypt_core;

    localparam logic [127:0] c_kat_key    = 128'h1b1a1918_13121110_0b0a0908_03020100;
    localparam logic [63:0]  c_kat_cipher = 64'h8c6fa548_454e028b;
    localparam logic [63:0]  c_kat_plain  = 64'h3b726574_7475432d;

    logic         clk = 1'b0;
    logic         reset_1;
    logic         start;
    logic         reuse_key;
    logic [63:0]  cipher_in;
    logic [127:0] key_in;
    logic [63:0]  plain_out;
    logic         busy;
    logic         done;
    logic         keys_valid;

    int n_tests = 0;
    int n_fail  = 0;

    // Model state: expanded schedule and whether the DUT should hold one.
    logic [31:0] m_rk [0:26];
    bit          m_kv = 1'b0;

    speck_decrypt_core #(.ROUNDS(27), .ALPHA(8), .BETA(3)) dut (
        .clk        (clk),
        .reset_1    (reset_1),
        .start      (start),
        .reuse_key  (reuse_key),
        .cipher_in  (cipher_in),
        .key_in     (key_in),
        .plain_out  (plain_out),
        .busy       (busy),
        .done       (done),
        .keys_valid (keys_valid)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ror(input logic [31:0] v, input int a);
        return (v >> a) | (v << (32 - a));
    endfunction

    function automatic logic [31:0] rol(input logic [31:0] v, input int a);
        return (v << a) | (v >> (32 - a));
    endfunction

    function automatic void m_expand(input logic [127:0] key);
        logic [31:0] l [0:29];
        logic [31:0] k;
        k    = key[31:0];
        l[0] = key[63:32];
        l[1] = key[95:64];
        l[2] = key[127:96];
        for (int i = 0; i < 27; i++) begin
            m_rk[i]  = k;
            l[i + 3] = (k + ror(l[i], 8)) ^ 32'(i);
            k        = rol(k, 3) ^ l[i + 3];
        end
    endfunction

    function automatic logic [63:0] m_encrypt(input logic [63:0] p);
        logic [31:0] x, y;
        x = p[63:32];
        y = p[31:0];
        for (int i = 0; i < 27; i++) begin
            x = (ror(x, 8) + y) ^ m_rk[i];
            y = rol(y, 3) ^ x;
        end
        return {x, y};
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Present a start request for one cycle; returns at the negedge after edge 0.
    task automatic start_op(input logic [63:0] c, input logic [127:0] k, input bit reuse);
        @(negedge clk);
        cipher_in = c;
        key_in    = k;
        reuse_key = reuse;
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        reuse_key = 1'($urandom);
        cipher_in = {$urandom, $urandom};
        key_in    = rand128();
    endtask

    // Count cycles until done, optionally pulsing start at two cycle indices.
    task automatic wait_done(input int limit, input int pa, input int pb,
                             output int cycles, output int ndone);
        cycles = 0;
        ndone  = 0;
        while (ndone == 0 && cycles < limit) begin
            if (cycles == pa || cycles == pb) begin
                start     = 1'b1;
                reuse_key = 1'($urandom);
                cipher_in = {$urandom, $urandom};
                key_in    = rand128();
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            cycles++;
            if (done) ndone++;
        end
        start = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (done) ndone++;
        end
    endtask

    task automatic do_run(input string tag, input logic [63:0] c, input logic [127:0] k,
                          input bit reuse, input logic [63:0] exp_plain,
                          input int pa, input int pb);
        int lat, cyc, nd;
        bit honoured;
        honoured = reuse && m_kv;
        if (!honoured) begin
            m_expand(k);
            m_kv = 1'b1;
        end
        lat = honoured ? 28 : 55;
        start_op(c, k, reuse);
        wait_done(200, pa, pb, cyc, nd);
        check_eq({tag, "_latency"}, 64'(cyc), 64'(lat));
        check_eq({tag, "_done_cnt"}, 64'(nd), 64'd1);
        check_eq({tag, "_plain"}, plain_out, exp_plain);
        check_eq({tag, "_keys_valid"}, 64'(keys_valid), 64'd1);
    endtask

    initial begin
        logic [127:0] k;
        logic [63:0]  p;
        int           nd;

        reset_1   = 1'b1;
        start     = 1'b0;
        reuse_key = 1'b0;
        cipher_in = '0;
        key_in    = '0;
        repeat (2) @(negedge clk);
        check_eq("rst_plain", plain_out, 64'd0);
        check_eq("rst_flags", {61'd0, busy, done, keys_valid}, 64'd0);
        reset_1 = 1'b0;

        // Known answer, full expansion, with ignored start pulses mid-run.
        do_run("kat_full", c_kat_cipher, c_kat_key, 1'b0, c_kat_plain, 10, 40);
        // Known answer reusing the stored schedule, key bus zero.
        do_run("kat_reuse", c_kat_cipher, 128'd0, 1'b1, c_kat_plain, 5, 20);

        // Round trip under two random keys.
        for (int kk = 0; kk < 2; kk++) begin
            k = rand128();
            m_expand(k);
            for (int pp = 0; pp < 5; pp++) begin
                p = {$urandom, $urandom};
                m_expand(k);
                if (pp == 0)
                    do_run("rt_full", m_encrypt(p), k, 1'b0, p, -1, -1);
                else
                    do_run("rt_reuse", m_encrypt(p), rand128(), 1'b1, p, -1, -1);
            end
        end

        // Reset in the middle of key expansion.
        start_op(c_kat_cipher, c_kat_key, 1'b0);
        repeat (10) @(negedge clk);
        check_eq("pre_rst_busy", 64'(busy), 64'd1);
        #2 reset_1 = 1'b1;
        #1;
        check_eq("rst_exp_plain", plain_out, 64'd0);
        check_eq("rst_exp_flags", {61'd0, busy, done, keys_valid}, 64'd0);
        @(negedge clk);
        reset_1 = 1'b0;
        m_kv    = 1'b0;
        do_run("post_rst_reuse", c_kat_cipher, c_kat_key, 1'b1, c_kat_plain, -1, -1);

        // Asynchronous reset between edges during decryption.
        start_op(c_kat_cipher, 128'd0, 1'b1);
        repeat (10) @(negedge clk);
        check_eq("pre_arst_busy", 64'(busy), 64'd1);
        #2 reset_1 = 1'b1;
        #1;
        check_eq("arst_plain", plain_out, 64'd0);
        check_eq("arst_flags", {61'd0, busy, done, keys_valid}, 64'd0);
        @(negedge clk);
        reset_1 = 1'b0;
        m_kv    = 1'b0;
        nd = 0;
        repeat (100) begin
            @(negedge clk);
            if (done) nd++;
        end
        check_eq("arst_no_done", 64'(nd), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
